camera_angle_ctrl: RTL and testbench
====================================

// Module: camera_angle_ctrl
// PURPOSE
//  Reader side of the 126-entry camera-angle ROM (7-bit addr, 80-bit word, 1-clk registered read).
//  Tracks the player heading index from turn inputs and fetches the matching ROM word once per frame.
//  Unpacks the word into dirX/dirY/planeX/planeY/invDet (Q8.8) and holds it stable for the raycaster
//  for the whole frame; cam_update pulses when new values are committed.
// PARAMETERS
//  N_ANGLES  126  number of ROM entries; heading index wraps modulo N_ANGLES
//  ADDR_W    7    width of rom_addr / angle_idx
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  frame_start  in   1   one-cycle pulse at start of frame (vsync edge)
//  turn_left    in   1   level; sampled only on frame_start
//  turn_right   in   1   level; sampled only on frame_start
//  rom_addr     out  7   address to angle ROM (registered)
//  rom_data     in   80  ROM word {dirX[79:64],dirY[63:48],planeX[47:32],planeY[31:16],invDet[15:0]}
//  dir_x, dir_y, plane_x, plane_y, inv_det  out  16 each  committed camera params, Q8.8 signed
//  angle_idx    out  7   committed heading index, 0..N_ANGLES-1
//  cam_valid    out  1   high once first word committed after reset; stays high
//  cam_update   out  1   one-cycle pulse on the cycle after each commit
//  busy         out  1   high in FETCH/CAPTURE
// BEHAVIOUR
//  - Reset: all outputs 0 (rom_addr=0, angle_idx=0, cam_valid=0, cam_update=0); state=FETCH, so
//    index 0 is fetched automatically without frame_start. rst mid-fetch aborts; restart from FETCH/idx 0.
//  - States: IDLE, FETCH (ROM registering rom_addr), CAPTURE (rom_data valid).
//    IDLE --frame_start & step!=0--> FETCH --> CAPTURE --> IDLE. FETCH/CAPTURE last exactly 1 cycle.
//  - Step on frame_start: right only = +1; left only = -1; both or neither = 0.
//    Next idx = (angle_idx+step) mod N_ANGLES: 125+1 -> 0, 0-1 -> 125. Computed without
//    relying on 7-bit overflow (N_ANGLES != 128).
//  - Edge k samples frame_start in IDLE: rom_addr <= next idx, state FETCH. Edge k+1: ROM
//    registers word, state CAPTURE. Edge k+2: all 5 fields and angle_idx <= rom_addr committed
//    together, cam_valid <= 1, cam_update high for the cycle after edge k+2.
//  - step==0 with cam_valid=1: no fetch, no cam_update, outputs unchanged.
//  - frame_start while busy: ignored (dropped, not queued); turn inputs not sampled.
//  - Outputs never change outside the commit edge; no partial field updates.
//  - rom_addr always < N_ANGLES; rom_data only sampled in CAPTURE.
// CONFIGURATION
//  CAM_TURN_ACCEL_EN defined: 3-bit saturating hold counter counts consecutive frame_start
//   pulses with the same single direction held; cleared on release, reversal, both, or rst.
//   When count >= 4 before the increment, step magnitude is 2 (wrap: 125+2 -> 1, 0-2 -> 124,
//   1-2 -> 125). A dropped (busy) frame_start does not advance the counter.
//  Not defined: step magnitude always 1; no counter logic synthesized.
// TESTING
//  1 rst 3 clks, release -> cam_valid=1 and cam_update pulse 2 clks after release, angle_idx=0,
//    fields = ROM word 0, rom_addr=0 throughout.
//  2 turn_right held, frame_start at idx 125 -> rom_addr=0 next clk; commit 2 clks later,
//    angle_idx=0, one cam_update pulse.
//  3 turn_left at idx 0 -> angle_idx=125, fields = ROM word 125;
//    both turns held -> no fetch, no cam_update.
//  4 frame_start on consecutive cycles -> 2nd pulse ignored, single step, busy=1 during FETCH/CAPTURE.
//  5 rst asserted in CAPTURE of fetch to idx 40 -> outputs 0, then idx 0 fetched; idx 40 never committed.
//  6 (CAM_TURN_ACCEL_EN) turn_right held 6 frames from idx 120 ->
//    idx 121,122,123,124,0,2; release then right -> +1.

Source files
------------

// File: rtl/camera_angle_ctrl.sv
`default_nettype none
// camera_angle_ctrl: tracks the heading index and commits one angle-ROM word per frame as Q8.8 camera params.
// Optional build macro CAM_TURN_ACCEL_EN: double-rate turning after four consecutive held-turn frames.
module camera_angle_ctrl #(
  parameter int N_ANGLES = 126,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              turn_left,
  input  logic              turn_right,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [79:0]       rom_data,
  output logic [15:0]       dir_x,
  output logic [15:0]       dir_y,
  output logic [15:0]       plane_x,
  output logic [15:0]       plane_y,
  output logic [15:0]       inv_det,
  output logic [ADDR_W-1:0] angle_idx,
  output logic              cam_valid,
  output logic              cam_update,
  output logic              busy
);

  localparam logic [ADDR_W:0] c_N = (ADDR_W+1)'(N_ANGLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_commit;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic [ADDR_W-1:0]   r_angle_idx;
  logic [15:0]         r_dir_x, r_dir_y, r_plane_x, r_plane_y, r_inv_det;
  logic                r_cam_valid;
  logic                r_cam_update;

  logic                w_right_only;
  logic                w_left_only;
  logic                w_step_nz;
  logic [ADDR_W:0]     w_mag;
  logic [ADDR_W:0]     w_base;
  logic [ADDR_W:0]     w_sum;
  logic [ADDR_W:0]     w_next;

  assign w_right_only = turn_right & ~turn_left;
  assign w_left_only  = turn_left & ~turn_right;
  assign w_step_nz    = w_right_only | w_left_only;

`ifdef CAM_TURN_ACCEL_EN
  logic       r_hold_right;
  logic [2:0] r_hold_cnt;
  logic       w_sample;
  logic       w_same_dir;

  assign w_sample   = (r_state == S_IDLE) & frame_start;
  assign w_same_dir = (r_hold_cnt != 3'd0) && (r_hold_right == turn_right);
  assign w_mag      = (w_same_dir && (r_hold_cnt >= 3'd4)) ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);

  // Only accepted frame_start pulses (sampled in IDLE) advance or clear the hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt   <= 3'd0;
      r_hold_right <= 1'b0;
    end else if (w_sample) begin
      if (w_step_nz) begin
        if (w_same_dir)
          r_hold_cnt <= (r_hold_cnt == 3'd7) ? 3'd7 : r_hold_cnt + 3'd1;
        else
          r_hold_cnt <= 3'd1;
        r_hold_right <= turn_right;
      end else begin
        r_hold_cnt <= 3'd0;
      end
    end
  end
`else
  assign w_mag = (ADDR_W+1)'(1);
`endif

  // Wrap explicitly against N_ANGLES; plain ADDR_W overflow would wrap at 128.
  assign w_base = {1'b0, r_angle_idx};
  assign w_sum  = w_base + w_mag;
  always_comb begin
    w_next = w_base;
    if (w_right_only)
      w_next = (w_sum >= c_N) ? (w_sum - c_N) : w_sum;
    else if (w_left_only)
      w_next = (w_base >= w_mag) ? (w_base - w_mag) : (w_base + c_N - w_mag);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start && w_step_nz) begin
          w_accept    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Reset lands in FETCH with address 0 so the first word loads without a frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_rom_addr   <= '0;
      r_angle_idx  <= '0;
      r_dir_x      <= 16'd0;
      r_dir_y      <= 16'd0;
      r_plane_x    <= 16'd0;
      r_plane_y    <= 16'd0;
      r_inv_det    <= 16'd0;
      r_cam_valid  <= 1'b0;
      r_cam_update <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cam_update <= w_commit;
      if (w_accept)
        r_rom_addr <= w_next[ADDR_W-1:0];
      if (w_commit) begin
        r_dir_x     <= rom_data[79:64];
        r_dir_y     <= rom_data[63:48];
        r_plane_x   <= rom_data[47:32];
        r_plane_y   <= rom_data[31:16];
        r_inv_det   <= rom_data[15:0];
        r_angle_idx <= r_rom_addr;
        r_cam_valid <= 1'b1;
      end
    end
  end

  assign rom_addr   = r_rom_addr;
  assign angle_idx  = r_angle_idx;
  assign dir_x      = r_dir_x;
  assign dir_y      = r_dir_y;
  assign plane_x    = r_plane_x;
  assign plane_y    = r_plane_y;
  assign inv_det    = r_inv_det;
  assign cam_valid  = r_cam_valid;
  assign cam_update = r_cam_update;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_camera_angle_ctrl.sv
`default_nettype none
// tb_camera_angle_ctrl: randomized + directed stimulus, reference heading model and commit scoreboard.
module tb_camera_angle_ctrl;

  localparam int N = 126;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        turn_left = 1'b0;
  logic        turn_right = 1'b0;
  logic [6:0]  rom_addr;
  logic [79:0] rom_data = 80'd0;
  logic [15:0] dir_x, dir_y, plane_x, plane_y, inv_det;
  logic [6:0]  angle_idx;
  logic        cam_valid, cam_update, busy;

  camera_angle_ctrl #(.N_ANGLES(N), .ADDR_W(7)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .turn_left(turn_left),
    .turn_right(turn_right), .rom_addr(rom_addr), .rom_data(rom_data),
    .dir_x(dir_x), .dir_y(dir_y), .plane_x(plane_x), .plane_y(plane_y),
    .inv_det(inv_det), .angle_idx(angle_idx), .cam_valid(cam_valid),
    .cam_update(cam_update), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [79:0] rom [N];
  always @(posedge clk) if (rom_addr < 7'(N)) rom_data <= rom[rom_addr];

  longint cyc = 0;
  logic   rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  typedef struct {int idx; longint due;} exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: heading, accel hold state, and how many more cycles the DUT stays busy.
  int m_idx = 0;
  int m_cnt = 0;
  int m_dir = 0;
  int busy_cnt = 0;

  task automatic tick(input logic fs, input logic l, input logic r);
    int dir, mag;
    bit acc;
    @(negedge clk);
    if (!rst_q) chk("busy", 96'(busy), 96'(busy_cnt != 0));
    frame_start = fs;
    turn_left   = l;
    turn_right  = r;
    acc = 1'b0;
    if (fs && busy_cnt == 0) begin
      dir = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
      mag = 1;
`ifdef CAM_TURN_ACCEL_EN
      if (dir != 0) begin
        if (dir == m_dir && m_cnt >= 4) mag = 2;
        if (dir == m_dir && m_cnt > 0) m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
        else m_cnt = 1;
        m_dir = dir;
      end else begin
        m_cnt = 0;
      end
`endif
      if (dir != 0) begin
        m_idx = (m_idx + dir * mag + N) % N;
        sb.push_back('{idx: m_idx, due: cyc + 3});
        acc = 1'b1;
      end
    end
    busy_cnt = acc ? 2 : ((busy_cnt > 0) ? busy_cnt - 1 : 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    frame_start = 1'b0;
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_idx = 0;
    m_cnt = 0;
    m_dir = 0;
    sb.delete();
    sb.push_back('{idx: 0, due: cyc + 2});
    busy_cnt = 1;
  endtask

  // Monitor: checks reset values, every commit against the scoreboard, and hold-stability otherwise.
  initial begin
    logic [86:0] held;
    logic        held_v;
    exp_t        e;
    held = '0;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      chk("rom_addr_range", 96'(rom_addr < 7'(N)), 96'(1));
      if (rst_q) begin
        chk("reset_outputs", 96'({angle_idx, dir_x, dir_y, plane_x, plane_y, inv_det, rom_addr}), 96'(0));
        chk("reset_flags", 96'({cam_valid, cam_update}), 96'(0));
        held = '0;
        held_v = 1'b0;
      end else if (cam_update) begin
        if (sb.size() == 0) begin
          chk("unexpected_update", 96'(1), 96'(0));
        end else begin
          e = sb.pop_front();
          chk("commit_cycle", 96'(cyc), 96'(e.due));
          chk("commit_idx", 96'(angle_idx), 96'(e.idx));
          chk("commit_fields", 96'({dir_x, dir_y, plane_x, plane_y, inv_det}), 96'(rom[e.idx]));
          chk("commit_valid", 96'(cam_valid), 96'(1));
          held = {7'(e.idx), rom[e.idx]};
          held_v = 1'b1;
        end
      end else begin
        chk("hold_stable", 96'({angle_idx, dir_x, dir_y, plane_x, plane_y, inv_det}), 96'(held));
        chk("hold_valid", 96'(cam_valid), 96'(held_v));
      end
    end
  end

  initial begin
    int d;
    for (int i = 0; i < N; i++) rom[i] = {16'($urandom), 32'($urandom), 32'($urandom)};

    do_reset(3);
    repeat (3) tick(0, 0, 0);
    tick(1, 1, 0);                      // 0 -> 125
    repeat (3) tick(0, 0, 0);
    tick(1, 0, 1);                      // 125 -> 0
    repeat (3) tick(0, 0, 0);
    tick(1, 1, 1);                      // both: no fetch
    repeat (3) tick(0, 1, 1);
    tick(1, 0, 0);                      // neither: no fetch
    repeat (3) tick(0, 0, 0);
    repeat (4) tick(1, 0, 1);           // back-to-back: 2nd and 3rd dropped
    repeat (3) tick(0, 0, 0);
    tick(1, 0, 1);                      // reset lands in CAPTURE of this fetch
    tick(0, 0, 1);
    do_reset(2);
    repeat (4) tick(0, 0, 0);
    for (int i = 0; i < 140; i++) begin // long right hold crosses the wrap point
      tick(1, 0, 1);
      repeat (2) tick(0, 0, 1);
    end
    tick(1, 0, 0);
    repeat (2) tick(0, 0, 0);
    for (int i = 0; i < 70; i++) begin  // long left hold crosses 0 downwards
      tick(1, 1, 0);
      repeat (2) tick(0, 1, 0);
    end

    d = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) d = int'($urandom_range(0, 3));
      if ($urandom_range(0, 599) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        tick($urandom_range(0, 2) == 0, d == 1 || d == 3, d == 2 || d == 3);
      end
    end

    repeat (6) tick(0, 0, 0);
    chk("scoreboard_drained", 96'(sb.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
